// File: rtl/ads131_init_sequencer.sv
// ADS131A0X bring-up sequencer: hardware reset, fixed command list with echo checks,
// then one NULL frame per DRDY conversion while reporting ready/error/overrun status.
module ads131_init_sequencer #(
  parameter int unsigned RESET_CYCLES    = 1000,
  parameter int unsigned POR_WAIT_CYCLES = 5000,
  parameter int unsigned READY_RETRIES   = 255,
  parameter int unsigned TIMEOUT_CYCLES  = 4096,
  parameter logic [7:0]  CFG_ADDR        = 8'h0E,
  parameter logic [7:0]  CFG_DATA        = 8'h86,
  parameter logic [7:0]  ADC_ENA_VAL     = 8'h0F
) (
  input  logic        system_clock,
  input  logic        reset_n,
  input  logic        restart,
  input  logic        drdy_n,
  output logic        frame_start,
  output logic [15:0] frame_cmd,
  input  logic        frame_busy,
  input  logic        frame_done,
  input  logic [15:0] frame_rx,
  output logic        adc_reset_n,
  output logic        ready,
  output logic        error,
  output logic [3:0]  error_step,
  output logic        overrun,
  output logic [15:0] status_word,
  output logic [15:0] conv_count
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned STEP_W  = 3;
  localparam int unsigned RETRY_W = 8;
  localparam int unsigned WORD_W  = 16;

  localparam logic [WORD_W-1:0] NULL_CMD  = 16'h0000;
  localparam logic [WORD_W-1:0] READY_RSP = 16'hFF04;
  localparam logic [7:0] CFG_WREG_HDR = 8'h40 | {3'b000, CFG_ADDR[4:0]};
  localparam logic [7:0] CFG_ECHO_HDR = 8'h20 | {3'b000, CFG_ADDR[4:0]};

  typedef enum logic [2:0] {
    S_HOLD_RST, S_POR_WAIT, S_POLL, S_CMD, S_RSP, S_RUN, S_ERROR
  } state_e;

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    tmo_q, tmo_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic                outstanding_q, outstanding_d;
  logic                pend_q, pend_d;
  logic                frame_start_q, frame_start_d;
  logic [WORD_W-1:0]   frame_cmd_q, frame_cmd_d;
  logic                adc_reset_n_q, adc_reset_n_d;
  logic                ready_q, ready_d;
  logic                error_q, error_d;
  logic [3:0]          error_step_q, error_step_d;
  logic                overrun_q, overrun_d;
  logic [WORD_W-1:0]   status_word_q, status_word_d;
  logic [WORD_W-1:0]   conv_count_q, conv_count_d;
  logic                drdy_s1_q, drdy_s2_q, drdy_s3_q, drdy_fall_q;

  logic [WORD_W-1:0]   cmd_c, exp_c, issue_cmd_c;
  logic                done_c, timeout_c, drdy_evt_c;
  logic                issue_c, fail_c, restart_c;

  // Command word and expected echo for the current bring-up step
  always_comb begin
    cmd_c = NULL_CMD;
    exp_c = READY_RSP;
    case (step_q)
      3'd1: begin cmd_c = 16'h0655;                     exp_c = 16'h0655; end
      3'd2: begin cmd_c = {CFG_WREG_HDR, CFG_DATA};     exp_c = {CFG_ECHO_HDR, CFG_DATA}; end
      3'd3: begin cmd_c = {8'h4F, ADC_ENA_VAL};         exp_c = {8'h2F, ADC_ENA_VAL}; end
      3'd4: begin cmd_c = 16'h0033;                     exp_c = 16'h0033; end
      3'd5: begin cmd_c = 16'h0555;                     exp_c = 16'h0555; end
      default: begin cmd_c = NULL_CMD;                  exp_c = READY_RSP; end
    endcase
  end

  assign done_c     = outstanding_q & frame_done;
  assign timeout_c  = outstanding_q & ~frame_done & (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign drdy_evt_c = drdy_fall_q | pend_q;

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    retry_d       = retry_q;
    outstanding_d = outstanding_q;
    pend_d        = 1'b0;
    frame_start_d = 1'b0;
    frame_cmd_d   = frame_cmd_q;
    adc_reset_n_d = adc_reset_n_q;
    ready_d       = ready_q;
    error_d       = error_q;
    error_step_d  = error_step_q;
    overrun_d     = overrun_q;
    status_word_d = status_word_q;
    conv_count_d  = conv_count_q;
    issue_c       = 1'b0;
    issue_cmd_c   = NULL_CMD;
    fail_c        = 1'b0;
    restart_c     = 1'b0;

    if (outstanding_q) tmo_d = tmo_q + CNT_W'(1);

    case (state_q)
      S_HOLD_RST: begin
        adc_reset_n_d = 1'b0;
        if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
          cnt_d         = '0;
          adc_reset_n_d = 1'b1;
          state_d       = S_POR_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_POR_WAIT: begin
        if (cnt_q == CNT_W'(POR_WAIT_CYCLES - 1)) begin
          cnt_d   = '0;
          step_d  = '0;
          retry_d = '0;
          state_d = S_POLL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_POLL: begin
        if (timeout_c) begin
          fail_c = 1'b1;
        end else if (done_c) begin
          if (frame_rx == READY_RSP) begin
            step_d  = STEP_W'(1);
            state_d = S_CMD;
          end else if ((retry_q + RETRY_W'(1)) >= RETRY_W'(READY_RETRIES)) begin
            fail_c = 1'b1;
          end else begin
            retry_d = retry_q + RETRY_W'(1);
          end
        end else if (!outstanding_q && !frame_busy) begin
          issue_c = 1'b1;
        end
      end
      S_CMD: begin
        if (timeout_c) begin
          fail_c = 1'b1;
        end else if (done_c) begin
          state_d = S_RSP;
        end else if (!outstanding_q && !frame_busy) begin
          issue_c     = 1'b1;
          issue_cmd_c = cmd_c;
        end
      end
      S_RSP: begin
        if (timeout_c) begin
          fail_c = 1'b1;
        end else if (done_c) begin
          if (frame_rx != exp_c) begin
            fail_c = 1'b1;
          end else if (step_q == STEP_W'(5)) begin
            ready_d = 1'b1;
            state_d = S_RUN;
          end else begin
            step_d  = step_q + STEP_W'(1);
            state_d = S_CMD;
          end
        end else if (!outstanding_q && !frame_busy) begin
          issue_c = 1'b1;
        end
      end
      S_RUN: begin
        if (restart) begin
          restart_c = 1'b1;
        end else if (timeout_c) begin
          fail_c = 1'b1;
        end else if (done_c) begin
          // A DRDY edge coinciding with completion is deferred one cycle, not an overrun
          status_word_d = frame_rx;
          conv_count_d  = conv_count_q + WORD_W'(1);
          pend_d        = drdy_evt_c;
        end else if (drdy_evt_c) begin
          if (outstanding_q)    overrun_d = 1'b1;
          else if (!frame_busy) issue_c   = 1'b1;
          else                  pend_d    = 1'b1;
        end
      end
      S_ERROR: begin
        if (restart) restart_c = 1'b1;
      end
      default: state_d = S_HOLD_RST;
    endcase

    if (done_c) outstanding_d = 1'b0;

    if (issue_c) begin
      frame_start_d = 1'b1;
      frame_cmd_d   = issue_cmd_c;
      outstanding_d = 1'b1;
      tmo_d         = '0;
    end

    if (fail_c) begin
      state_d       = S_ERROR;
      error_d       = 1'b1;
      error_step_d  = (state_q == S_RUN) ? 4'hF : 4'(step_q);
      ready_d       = 1'b0;
      outstanding_d = 1'b0;
    end

    if (restart_c) begin
      state_d       = S_HOLD_RST;
      step_d        = '0;
      cnt_d         = '0;
      retry_d       = '0;
      outstanding_d = 1'b0;
      pend_d        = 1'b0;
      adc_reset_n_d = 1'b0;
      ready_d       = 1'b0;
      error_d       = 1'b0;
      error_step_d  = 4'h0;
      overrun_d     = 1'b0;
      conv_count_d  = '0;
    end
  end

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_HOLD_RST;
      step_q        <= '0;
      cnt_q         <= '0;
      tmo_q         <= '0;
      retry_q       <= '0;
      outstanding_q <= 1'b0;
      pend_q        <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cmd_q   <= '0;
      adc_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
      error_q       <= 1'b0;
      error_step_q  <= 4'h0;
      overrun_q     <= 1'b0;
      status_word_q <= '0;
      conv_count_q  <= '0;
      drdy_s1_q     <= 1'b1;
      drdy_s2_q     <= 1'b1;
      drdy_s3_q     <= 1'b1;
      drdy_fall_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      retry_q       <= retry_d;
      outstanding_q <= outstanding_d;
      pend_q        <= pend_d;
      frame_start_q <= frame_start_d;
      frame_cmd_q   <= frame_cmd_d;
      adc_reset_n_q <= adc_reset_n_d;
      ready_q       <= ready_d;
      error_q       <= error_d;
      error_step_q  <= error_step_d;
      overrun_q     <= overrun_d;
      status_word_q <= status_word_d;
      conv_count_q  <= conv_count_d;
      drdy_s1_q     <= drdy_n;
      drdy_s2_q     <= drdy_s1_q;
      drdy_s3_q     <= drdy_s2_q;
      drdy_fall_q   <= drdy_s3_q & ~drdy_s2_q;
    end
  end

  assign frame_start = frame_start_q;
  assign frame_cmd   = frame_cmd_q;
  assign adc_reset_n = adc_reset_n_q;
  assign ready       = ready_q;
  assign error       = error_q;
  assign error_step  = error_step_q;
  assign overrun     = overrun_q;
  assign status_word = status_word_q;
  assign conv_count  = conv_count_q;

endmodule

// File: tb/tb_ads131_init_sequencer.sv
// Bench for ads131_init_sequencer: frame-engine/ADC model plus a queue of expected
// command words checked by a monitor on every frame_start.
module tb_ads131_init_sequencer;

  localparam int unsigned RST_C   = 20;
  localparam int unsigned POR_C   = 30;
  localparam int unsigned RETRY_C = 4;
  localparam int unsigned TMO_C   = 64;

  logic        system_clock;
  logic        reset_n, restart, drdy_n;
  logic        frame_start, frame_busy, frame_done;
  logic [15:0] frame_cmd, frame_rx;
  logic        adc_reset_n, ready, error, overrun;
  logic [3:0]  error_step;
  logic [15:0] status_word, conv_count;

  ads131_init_sequencer #(
    .RESET_CYCLES(RST_C), .POR_WAIT_CYCLES(POR_C), .READY_RETRIES(RETRY_C),
    .TIMEOUT_CYCLES(TMO_C), .CFG_ADDR(8'h0E), .CFG_DATA(8'h86), .ADC_ENA_VAL(8'h0F)
  ) dut (
    .system_clock(system_clock), .reset_n(reset_n), .restart(restart), .drdy_n(drdy_n),
    .frame_start(frame_start), .frame_cmd(frame_cmd), .frame_busy(frame_busy),
    .frame_done(frame_done), .frame_rx(frame_rx), .adc_reset_n(adc_reset_n),
    .ready(ready), .error(error), .error_step(error_step), .overrun(overrun),
    .status_word(status_word), .conv_count(conv_count)
  );

  initial system_clock = 1'b0;
  always #10 system_clock = ~system_clock;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] nom_seq [13] = '{16'h0000, 16'h0000, 16'h0000, 16'h0655, 16'h0000,
                                16'h4E86, 16'h0000, 16'h4F0F, 16'h0000, 16'h0033,
                                16'h0000, 16'h0555, 16'h0000};

  // ADC model knobs and state
  int          ready_after = 3;
  bit          bad_ena     = 1'b0;
  bit          withhold    = 1'b0;
  int          latency     = 5;
  logic [15:0] prev_cmd    = 16'h0000;
  int          polls       = 0;
  bit          seen_ready  = 1'b0;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    prev_cmd   = 16'h0000;
    polls      = 0;
    seen_ready = 1'b0;
  endtask

  // The ADC answers the previous command in the current frame
  task automatic adc_reply(input logic [15:0] cmd, output logic [15:0] rx);
    rx = 16'h0000;
    if (ready) rx = 16'h2200;
    else begin
      case (prev_cmd)
        16'h0000: if (cmd == 16'h0000 && !seen_ready) begin
                    polls++;
                    if (ready_after != 0 && polls == ready_after) begin
                      rx = 16'hFF04;
                      seen_ready = 1'b1;
                    end
                  end
        16'h0655: rx = 16'h0655;
        16'h4E86: rx = 16'h2E86;
        16'h4F0F: rx = bad_ena ? 16'h2F00 : 16'h2F0F;
        16'h0033: rx = 16'h0033;
        16'h0555: rx = 16'h0555;
        default:  rx = 16'h0000;
      endcase
    end
    prev_cmd = cmd;
  endtask

  // Frame engine model
  initial begin : engine
    int          cnt;
    logic        pending;
    logic [15:0] cur;
    cnt = 0; pending = 1'b0; cur = 16'h0000;
    frame_busy = 1'b0; frame_done = 1'b0; frame_rx = 16'h0000;
    forever begin
      @(posedge system_clock); #1;
      frame_done = 1'b0;
      if (reset_n !== 1'b1) begin
        pending = 1'b0; frame_busy = 1'b0;
      end else if (pending) begin
        if (cnt <= 1) begin
          pending = 1'b0; frame_busy = 1'b0;
          if (!withhold) begin frame_done = 1'b1; frame_rx = cur; end
        end else cnt--;
      end else if (frame_start === 1'b1) begin
        pending = 1'b1; frame_busy = 1'b1; cnt = latency;
        adc_reply(frame_cmd, cur);
      end
    end
  end

  // Monitor: every issued frame must match the head of the expected queue
  initial begin : monitor
    logic [15:0] e;
    forever begin
      @(negedge system_clock);
      if (reset_n === 1'b1 && frame_start === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame: got cmd %h expected no frame", frame_cmd);
        end else begin
          e = exp_q.pop_front();
          check16("frame_cmd", frame_cmd, e);
        end
      end
    end
  end

  function automatic bit cond_met(input int sel);
    case (sel)
      0:       return ready === 1'b1;
      1:       return error === 1'b1;
      default: return exp_q.size() == 0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int max, input string name);
    int n;
    n = 0;
    while (n < max && !cond_met(sel)) begin
      @(negedge system_clock);
      n++;
    end
    checks++;
    if (!cond_met(sel)) begin
      errors++;
      $display("FAIL %s: got no event after %0d cycles expected event", name, max);
    end
  endtask

  task automatic measure_reset(input string name);
    int n;
    n = 0;
    while (n < int'(4 * RST_C)) begin
      @(negedge system_clock);
      if (adc_reset_n === 1'b1) break;
      n++;
    end
    check16(name, 16'(n), 16'(RST_C));
  endtask

  task automatic restart_pulse();
    @(posedge system_clock); #1 restart = 1'b1;
    @(posedge system_clock); #1 restart = 1'b0;
  endtask

  task automatic drdy_pulse();
    drdy_n = 1'b0;
    repeat (4) @(posedge system_clock);
    #1 drdy_n = 1'b1;
    repeat (4) @(posedge system_clock);
    #1;
  endtask

  task automatic push_nominal();
    foreach (nom_seq[i]) exp_q.push_back(nom_seq[i]);
  endtask

  task automatic check_reset_values(input string tag);
    check16({tag, "_adc_reset_n"}, 16'(adc_reset_n), 16'h0);
    check16({tag, "_frame_start"}, 16'(frame_start), 16'h0);
    check16({tag, "_frame_cmd"},   frame_cmd,        16'h0);
    check16({tag, "_ready"},       16'(ready),       16'h0);
    check16({tag, "_error"},       16'(error),       16'h0);
    check16({tag, "_error_step"},  16'(error_step),  16'h0);
    check16({tag, "_overrun"},     16'(overrun),     16'h0);
    check16({tag, "_status_word"}, status_word,      16'h0);
    check16({tag, "_conv_count"},  conv_count,       16'h0);
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: got no finish expected finish within 5ms");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    reset_n = 1'b0; restart = 1'b0; drdy_n = 1'b1;
    model_reset();
    repeat (3) @(posedge system_clock);
    #1 check_reset_values("por");

    // Nominal bring-up, READY on the third poll
    @(posedge system_clock); #1 reset_n = 1'b1;
    push_nominal();
    measure_reset("adc_reset_len_por");
    wait_for(0, 2000, "nominal_ready");
    check16("nominal_error", 16'(error), 16'h0);
    check16("nominal_queue", 16'(exp_q.size()), 16'h0);

    // RUN service: 10 conversions
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(16'h0000);
      drdy_pulse();
      repeat (192) @(posedge system_clock);
    end
    @(negedge system_clock);
    check16("run_conv_count", conv_count, 16'd10);
    check16("run_status_word", status_word, 16'h2200);
    check16("run_overrun", 16'(overrun), 16'h0);
    check16("run_queue", 16'(exp_q.size()), 16'h0);

    // Two DRDY falls during one long frame
    latency = 40;
    exp_q.push_back(16'h0000);
    drdy_pulse();
    drdy_pulse();
    drdy_pulse();
    repeat (60) @(posedge system_clock);
    latency = 5;
    @(negedge system_clock);
    check16("ovr_overrun", 16'(overrun), 16'h1);
    check16("ovr_conv_count", conv_count, 16'd11);

    // RUN frame with frame_done withheld
    withhold = 1'b1;
    exp_q.push_back(16'h0000);
    drdy_pulse();
    wait_for(1, 300, "timeout_error");
    check16("timeout_error_step", 16'(error_step), 16'hF);
    check16("timeout_ready", 16'(ready), 16'h0);
    withhold = 1'b0;

    // Bad ADC_ENA echo
    bad_ena = 1'b1; ready_after = 1; model_reset();
    restart_pulse();
    check16("restart_error", 16'(error), 16'h0);
    check16("restart_overrun", 16'(overrun), 16'h0);
    check16("restart_conv_count", conv_count, 16'h0);
    measure_reset("adc_reset_len_restart1");
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0655); exp_q.push_back(16'h0000);
    exp_q.push_back(16'h4E86); exp_q.push_back(16'h0000); exp_q.push_back(16'h4F0F);
    exp_q.push_back(16'h0000);
    wait_for(1, 2000, "badecho_error");
    check16("badecho_error_step", 16'(error_step), 16'h3);
    check16("badecho_adc_reset_n", 16'(adc_reset_n), 16'h1);
    repeat (100) @(negedge system_clock);
    check16("badecho_queue", 16'(exp_q.size()), 16'h0);

    // Clean re-run after restart
    bad_ena = 1'b0; ready_after = 3; model_reset();
    restart_pulse();
    measure_reset("adc_reset_len_restart2");
    push_nominal();
    wait_for(0, 2000, "rerun_ready");
    check16("rerun_error", 16'(error), 16'h0);
    check16("rerun_error_step", 16'(error_step), 16'h0);

    // READY never arrives
    ready_after = 0; model_reset();
    restart_pulse();
    measure_reset("adc_reset_len_restart3");
    repeat (RETRY_C) exp_q.push_back(16'h0000);
    wait_for(1, 2000, "noready_error");
    check16("noready_error_step", 16'(error_step), 16'h0);
    repeat (200) @(negedge system_clock);
    check16("noready_queue", 16'(exp_q.size()), 16'h0);

    // Asynchronous reset during step 2
    ready_after = 1; model_reset();
    restart_pulse();
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0655);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h4E86);
    wait_for(2, 2000, "step2_reached");
    repeat (2) @(negedge system_clock);
    #2 reset_n = 1'b0;
    #1 check_reset_values("async");
    exp_q.delete();
    model_reset();
    ready_after = 3;
    repeat (3) @(posedge system_clock);
    #1 reset_n = 1'b1;
    push_nominal();
    measure_reset("adc_reset_len_async");
    wait_for(0, 2000, "async_rerun_ready");
    check16("async_rerun_error", 16'(error), 16'h0);
    check16("async_rerun_queue", 16'(exp_q.size()), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ads131_init_sequencer.md
# ads131_init_sequencer

Command sequencer for the ADS131A0X front end. It drives the ADC hardware reset, then runs the fixed bring-up command list through the SPI frame engine and checks every response. It then services DRDY by issuing one NULL frame per conversion. It sits between top-level control and the SPI frame engine, owns the frame engine's command port, and reports ready, error and overrun status.

## Interface
- RESET_CYCLES, 1000: system_clock cycles that adc_reset_n is held low.
- POR_WAIT_CYCLES, 5000: cycles after adc_reset_n release before the first frame.
- READY_RETRIES, 255: maximum NULL frames polling for READY (1..255).
- TIMEOUT_CYCLES, 4096: maximum cycles from frame_start to frame_done.
- CFG_ADDR, 8'h0E: address of the configuration register write.
- CFG_DATA, 8'h86: data of the configuration register write.
- ADC_ENA_VAL, 8'h0F: value written to ADC_ENA (address 0x0F).
- system_clock  in  1  50 MHz clock.
- reset_n  in  1  asynchronous active-low reset.
- restart  in  1  one-cycle pulse; restarts from the hardware reset, accepted in RUN and ERROR only.
- drdy_n  in  1  ADC DRDY, asynchronous, active low.
- frame_start  out  1  one-cycle request for one SPI frame.
- frame_cmd  out  16  command word, stable from frame_start until frame_done.
- frame_busy  in  1  frame engine busy.
- frame_done  in  1  one-cycle pulse; frame_rx is valid in the same cycle.
- frame_rx  in  16  status word captured in the frame.
- adc_reset_n  out  1  ADC hardware reset, active low.
- ready  out  1  high in RUN.
- error  out  1  sticky error flag, cleared by reset_n or restart.
- error_step  out  4  step that failed; 4'hF means a timeout in RUN.
- overrun  out  1  sticky; set when DRDY falls while a frame is outstanding.
- status_word  out  16  last frame_rx seen in RUN.
- conv_count  out  16  number of completed RUN frames, wraps at 16 bits.

## Operation
- **Reset values:** adc_reset_n=0, frame_start=0, frame_cmd=16'h0000, ready=0, error=0, error_step=0, overrun=0, status_word=0, conv_count=0. State is HOLD_RST.
- **Assumption:** the ADC answers a command in the following frame, so each command step is a command frame followed by a NULL (0x0000) frame, and the NULL frame's frame_rx is checked.
- **Steps and expected responses:**
  - Step 0: poll with NULL frames; expect 16'hFF04. Frame count at most READY_RETRIES.
  - Step 1: UNLOCK 16'h0655; expect 16'h0655.
  - Step 2: WREG {8'h40|CFG_ADDR[4:0], CFG_DATA}; expect {8'h20|CFG_ADDR[4:0], CFG_DATA}.
  - Step 3: WREG {8'h4F, ADC_ENA_VAL}; expect {8'h2F, ADC_ENA_VAL}.
  - Step 4: WAKEUP 16'h0033; expect 16'h0033.
  - Step 5: LOCK 16'h0555; expect 16'h0555.
- **States:**
  - HOLD_RST: adc_reset_n=0 for RESET_CYCLES, then go to POR_WAIT.
  - POR_WAIT: adc_reset_n=1; after POR_WAIT_CYCLES go to POLL with step=0.
  - POLL: send a NULL frame. On a match go to CMD with step=1. On a mismatch, retry; when the retry count reaches READY_RETRIES, go to ERROR with error_step=0.
  - CMD: send the step's command frame, then go to RSP.
  - RSP: send a NULL frame and compare its frame_rx. On a match, go to the next step; after step 5 go to RUN. On a mismatch go to ERROR with error_step=step.
  - RUN: ready=1. A synchronized falling edge of drdy_n issues a NULL frame. On its frame_done, status_word<=frame_rx and conv_count increments. No response check in RUN.
  - ERROR: frame_start is never asserted. adc_reset_n stays 1. Wait for restart.
- **Frame handshake:**
  - frame_start is asserted only when frame_busy=0 and no frame is outstanding.
  - Exactly one frame_done is expected per frame_start.
  - A frame_done with no frame outstanding is ignored.
- **Timeout:** a per-frame counter starts at frame_start. Reaching TIMEOUT_CYCLES without frame_done goes to ERROR. error_step is the current step, or 4'hF in RUN.
- **Overrun:** a DRDY fall while a RUN frame is outstanding sets overrun and issues no extra frame. A DRDY fall with no frame outstanding is serviced.
- **restart:**
  - In RUN or ERROR: clears error, error_step, overrun, conv_count and ready, then enters HOLD_RST.
  - Ignored in all other states.
- **Simultaneous events:**
  - restart and frame_done in the same cycle: restart wins.
  - DRDY edge in the same cycle as frame_done: the edge is serviced on the next cycle with no overrun.
- **Asynchronous reset:** asserting reset_n mid-operation forces all reset values immediately, including adc_reset_n=0.

## Timing
- drdy_n passes through a 2-FF synchronizer plus an edge register, so frame_start follows the drdy_n fall by 3–4 cycles.
- frame_start is high for exactly one cycle. frame_cmd is valid in the same cycle.
- Check latency: the state or step changes in the cycle after frame_done. The next frame_start comes no earlier than 1 cycle after that.
- ready rises in the cycle after the step-5 NULL frame's frame_done, when it matches.
- error and error_step are registered together, one cycle after the failing frame_done or the timeout.
- adc_reset_n is low for exactly RESET_CYCLES cycles after reset_n deasserts or after restart.

## Test plan
- **Nominal bring-up:** the ADC model returns FF04 on the 3rd poll, then correct echoes. Required: frame_cmd sequence 0000,0000,0000,0655,0000,4E86,0000,4F0F,0000,0033,0000,0555,0000, then ready=1 and error=0.
- **READY never arrives:** frame_rx is always 0000 with READY_RETRIES=4. Required: exactly 4 NULL frames, then error=1, error_step=0, and no further frame_start.
- **Bad echo:** the ADC_ENA echo returns 2F00. Required: error=1, error_step=3. A later restart gives adc_reset_n low for RESET_CYCLES and a clean re-run to ready.
- **RUN service:** 10 drdy_n falls spaced 200 cycles apart, frame_rx=2200. Required: 10 frames, conv_count=10, status_word=2200, overrun=0.
- **Overrun and timeout:**
  - DRDY falls twice during one outstanding frame. Required: overrun=1 and one frame only.
  - frame_done is withheld. Required: error_step=F after TIMEOUT_CYCLES.
- **Async reset mid-step-2:** reset_n pulses low. Required: all outputs return to reset values immediately, then a full bring-up repeats.
